apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_wait_timer.sv | 36 +++
 rtl/apb_master_bridge.sv | 142 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB master bridge.
//   APB_ADDR_W / APB_DATA_W : default address / data widths
//   apb_state_e             : bridge FSM state encoding
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: ACCESS wait-state down-counter for the APB master bridge.
// Ports:
//   clk, presetn : clock, asynchronous active-low reset
//   load         : reload to TIMEOUT_CYCLES-1 (start of a new transfer)
//   dec          : one more ACCESS cycle without pready
//   expired      : terminal count reached; the current waiting cycle is the last allowed
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic presetn,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Counter holds the number of further waiting cycles tolerated after the
  // current one, so terminal count zero flags the TIMEOUT_CYCLES-th wait.
  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_INIT;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a valid/ready command into one APB transfer and
// returns the result on a valid/ready response channel.
// Ports:
//   clk, presetn                        : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_write/
//   cmd_addr/cmd_wdata                  : command channel
//   rsp_valid/rsp_ready/rsp_rdata/
//   rsp_err/rsp_timeout                 : response channel
//   psel/penable/pwrite/paddr/pwdata/
//   prdata/pready/pslverr               : APB master port
// Optional feature: define APB_MASTER_TIMEOUT_EN to end an ACCESS phase after
// TIMEOUT_CYCLES cycles without pready (response flagged err + timeout).
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel=1 penable=0, one cycle, pready ignored
// ACCESS | psel=1 penable=1 until pready (or timeout)
// RESP   | rsp_valid high until rsp_ready
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e state;
  logic       accept;
  logic       timeout_hit;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && (state == ST_IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
  logic timer_dec;
  logic timeout_q;

  assign timer_dec = (state == ST_ACCESS) && !pready;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .presetn (presetn),
    .load    (accept),
    .dec     (timer_dec),
    .expired (timeout_hit)
  );

  assign rsp_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      state     <= ST_IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_write ? cmd_wdata : '0;
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          penable <= 1'b1;
        end
        ST_ACCESS: begin
          // pready wins over a timeout landing on the same cycle
          if (pready) begin
            state     <= ST_RESP;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
`ifdef APB_MASTER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end else if (timeout_hit) begin
            state     <= ST_RESP;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
            timeout_q <= 1'b1;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: self-checking bench for apb_master_bridge.
// Directed vectors from a table, hand-written reset sequences, and random
// transfers checked against a transaction-level expectation model.
// Timeout scenarios run only when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;
  localparam int TO     = 16;

  logic              clk = 1'b0;
  logic              presetn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata = '0;
  logic              pready = 1'b0;
  logic              pslverr = 1'b0;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    int         lat;
    logic [7:0] rdata;
    logic       err;
    logic       to;
  } exp_t;

  // Transaction-level expectation: zero-wait response lands at cycle 3,
  // each wait state adds one; timeout ends after TO waiting ACCESS cycles.
  function automatic exp_t model(input logic wr, input logic [7:0] rd,
                                 input logic err, input int waits);
    exp_t e;
`ifdef APB_MASTER_TIMEOUT_EN
    if (waits >= TO) begin
      e.lat = 2 + TO; e.rdata = 8'h00; e.err = 1'b1; e.to = 1'b1;
      return e;
    end
`endif
    e.lat   = 3 + waits;
    e.rdata = wr ? 8'h00 : rd;
    e.err   = err;
    e.to    = 1'b0;
    return e;
  endfunction

  // One full transfer: issue command, play APB slave with `waits` wait states,
  // hold the response `hold` cycles, then consume it.
  task automatic run_xfer(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [7:0] wd, input int waits, input logic [7:0] rd,
                          input logic err, input int hold, input logic keep, input exp_t e);
    int cyc, acc, lat, first_acc;
    logic addr_ok, stable_ok;
    logic [7:0] r;
    logic re, rt;
    @(negedge clk);
    chk({tag, " cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    @(posedge clk); #1;
    if (!keep) cmd_valid = 1'b0;
    cmd_addr = $urandom; cmd_wdata = 8'($urandom); cmd_write = 1'($urandom);
    cyc = 1; acc = 0; lat = -1; first_acc = -1; addr_ok = 1'b1;
    while (cyc < 60) begin
      if (rsp_valid) begin lat = cyc; break; end
      if (psel && !penable) begin
        pready = 1'b1; prdata = 8'($urandom); pslverr = 1'($urandom);
      end else if (psel && penable) begin
        if (first_acc < 0) first_acc = cyc;
        if (acc == waits) begin pready = 1'b1; prdata = rd; pslverr = err; end
        else begin pready = 1'b0; prdata = 8'($urandom); pslverr = 1'($urandom); end
        acc++;
      end else begin
        pready = 1'($urandom); prdata = 8'($urandom); pslverr = 1'($urandom);
      end
      if (psel && (paddr !== addr || pwrite !== wr || pwdata !== (wr ? wd : 8'h00)))
        addr_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " rsp_latency"}, 64'(lat), 64'(e.lat));
    chk({tag, " first_access_cycle"}, 64'(first_acc), 64'd2);
    chk({tag, " access_cycles"}, 64'(acc), 64'(e.to ? TO : waits + 1));
    chk({tag, " apb_addr_ctrl_stable"}, 64'(addr_ok), 64'd1);
    chk({tag, " psel_penable_in_resp"}, 64'({psel, penable}), 64'd0);
    chk({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
    chk({tag, " rsp_err"}, 64'(rsp_err), 64'(e.err));
    chk({tag, " rsp_timeout"}, 64'(rsp_timeout), 64'(e.to));
    r = rsp_rdata; re = rsp_err; rt = rsp_timeout;
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      pready = 1'($urandom); prdata = 8'($urandom); pslverr = 1'($urandom);
      @(posedge clk); #1;
      if (!rsp_valid || rsp_rdata !== r || rsp_err !== re || rsp_timeout !== rt ||
          cmd_ready !== 1'b0 || psel !== 1'b0) stable_ok = 1'b0;
    end
    if (hold > 0) chk({tag, " resp_hold_stable"}, 64'(stable_ok), 64'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    chk({tag, " rsp_valid_after_ready"}, 64'(rsp_valid), 64'd0);
    chk({tag, " cmd_ready_after_resp"}, 64'(cmd_ready), 64'd1);
    chk({tag, " paddr_kept_in_idle"}, 64'(paddr), 64'(addr));
  endtask

  typedef struct {
    logic       wr;
    logic [31:0] addr;
    logic [7:0] wd;
    int         waits;
    logic [7:0] rd;
    logic       err;
    int         hold;
    logic       keep;
    int         x_lat;
    logic [7:0] x_rdata;
    logic       x_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    exp_t e;
    logic wr, er, kp;
    logic [31:0] ad;
    logic [7:0] wd, rd;
    int wt, hd;

    //            wr    addr       wdata  waits rdata  err   hold keep  lat rdata  err
    vecs[0] = '{1'b1, 32'h5,     8'hA7, 0,    8'h00, 1'b0, 0,   1'b0, 3,  8'h00, 1'b0};
    vecs[1] = '{1'b0, 32'h5,     8'h00, 2,    8'hA7, 1'b0, 0,   1'b0, 5,  8'hA7, 1'b0};
    vecs[2] = '{1'b0, 32'h20,    8'h00, 1,    8'h3C, 1'b1, 0,   1'b0, 4,  8'h3C, 1'b1};
    vecs[3] = '{1'b1, 32'h44,    8'h5A, 0,    8'h99, 1'b0, 5,   1'b1, 3,  8'h00, 1'b0};
    vecs[4] = '{1'b1, 32'hBEEF0, 8'h33, 3,    8'h77, 1'b1, 2,   1'b0, 6,  8'h00, 1'b1};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset psel_penable_pwrite", 64'({psel, penable, pwrite}), 64'd0);
    chk("reset paddr", 64'(paddr), 64'd0);
    chk("reset pwdata", 64'(pwdata), 64'd0);
    chk("reset rsp_valid_err_timeout", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'd0);
    chk("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
    @(negedge clk); presetn = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready first cycle after reset", 64'(cmd_ready), 64'd1);

    // Directed table
    foreach (vecs[i]) begin
      e.lat = vecs[i].x_lat; e.rdata = vecs[i].x_rdata; e.err = vecs[i].x_err; e.to = 1'b0;
      run_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].waits,
               vecs[i].rd, vecs[i].err, vecs[i].hold, vecs[i].keep, e);
    end

    // Reset pulsed during ACCESS
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h77;
    @(posedge clk); #1;
    cmd_valid = 1'b0; pready = 1'b1;
    @(posedge clk); #1;
    pready = 1'b0;
    chk("mid-reset in ACCESS", 64'({psel, penable}), 64'b11);
    @(posedge clk); #2;
    presetn = 1'b0;
    #1;
    chk("async reset psel_penable", 64'({psel, penable}), 64'd0);
    chk("async reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async reset paddr", 64'(paddr), 64'd0);
    @(negedge clk); presetn = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready after reset release", 64'(cmd_ready), 64'd1);
    begin
      logic quiet = 1'b1;
      for (int i = 0; i < 4; i++) begin
        pready = 1'b1;
        @(posedge clk); #1;
        if (rsp_valid || psel) quiet = 1'b0;
      end
      chk("no response after abandoned transfer", 64'(quiet), 64'd1);
    end
    pready = 1'b0;

`ifdef APB_MASTER_TIMEOUT_EN
    run_xfer("timeout", 1'b0, 32'h30, 8'h00, 40, 8'h11, 1'b0, 1, 1'b0, model(1'b0, 8'h11, 1'b0, 40));
    run_xfer("pready_on_last_wait", 1'b0, 32'h31, 8'h00, TO - 1, 8'h6D, 1'b0, 0, 1'b0,
             model(1'b0, 8'h6D, 1'b0, TO - 1));
`endif

    // Random transfers against the model
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom); ad = $urandom; wd = 8'($urandom); rd = 8'($urandom);
      er = ($urandom_range(0, 3) == 0); hd = $urandom_range(0, 3); kp = 1'($urandom);
      wt = $urandom_range(0, 5);
`ifdef APB_MASTER_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) wt = TO + $urandom_range(0, 4);
`endif
      e = model(wr, rd, er, wt);
      run_xfer($sformatf("rnd%0d", n), wr, ad, wd, wt, rd, er, hd, kp, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
